// File: rtl/shift_pkg.sv
// Shared types for the shift scheduler slice.
//   shift_op_t    : operation encoding carried on req_op0/req_op1
//   sched_state_t : scheduler FSM states
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL     = 2'd0,
    SHIFT_SRL     = 2'd1,
    SHIFT_SRA     = 2'd2,
    SHIFT_ILLEGAL = 2'd3
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/shift_scheduler_if.sv
// Request/response bundle between two shift requesters, the scheduler and
// the result consumer.
//   req_valid/req_ready        : per-requester handshake, bit i = requester i
//   req_op*, req_in*, req_shamt*: operation fields of requester 0 and 1
//   rsp_valid/rsp_ready        : result handshake
//   rsp_data, rsp_id, rsp_err  : result, issuing requester, illegal-op flag
// Modports: master = requesters + consumer, slave = scheduler.
interface shift_scheduler_if #(
  parameter int N = 32
);
  localparam int SW = $clog2(N);

  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_op0;
  logic [1:0]    req_op1;
  logic [N-1:0]  req_in0;
  logic [N-1:0]  req_in1;
  logic [SW-1:0] req_shamt0;
  logic [SW-1:0] req_shamt1;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          rsp_id;
  logic          rsp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_in0, req_in1, req_shamt0, req_shamt1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_in0, req_in1, req_shamt0, req_shamt1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   req        : request vector
//   last_grant : index granted most recently; the other index wins a tie
//   en         : grant permitted this cycle
//   grant      : one-hot grant (all zero when disabled or no request)
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  assign grant[0] = en & req[0] & (~req[1] |  last_grant);
  assign grant[1] = en & req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/shift_scheduler.sv
// Arbitrates two requesters onto one shift datapath, one operation in flight.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : shift_scheduler_if slave port (request and response handshakes)
// Flow: IDLE/RESP-handoff accepts a request -> CALC (operands held, shifter
// evaluates, result registers load) -> RESP (result held until rsp_ready).
module shift_scheduler
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  shift_scheduler_if.slave bus
);

  localparam int SW = $clog2(N);

  sched_state_t  state_q, state_d;
  logic          last_grant_q;
  shift_op_t     op_q;
  logic [N-1:0]  in_q;
  logic [SW-1:0] shamt_q;
  logic          id_q;

  logic          accept_en;
  logic [1:0]    grant;
  logic          xfer;
  logic          xfer_id;

  logic [N-1:0]  sll_res, srl_res, sra_res;
  logic [N-1:0]  result;
  logic          result_err;

  logic [N-1:0]  rsp_data_q;
  logic          rsp_id_q;
  logic          rsp_err_q;

  // Accept only when nothing is held, or the held result leaves this cycle.
  // Gated by rst so no request is acknowledged while reset is asserted.
  assign accept_en = ~rst & ((state_q == S_IDLE) |
                             ((state_q == S_RESP) & bus.rsp_ready));

  rr_arbiter2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .en         (accept_en),
    .grant      (grant)
  );

  assign bus.req_ready = grant;
  assign xfer          = |grant;   // grant already implies the matching valid
  assign xfer_id       = grant[1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (xfer) state_d = S_CALC;
      S_CALC:  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = xfer ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on transfer. last_grant resets to 1 so requester 0 wins
  // the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      op_q         <= SHIFT_SLL;
      in_q         <= '0;
      shamt_q      <= '0;
      id_q         <= 1'b0;
    end else if (xfer) begin
      last_grant_q <= xfer_id;
      id_q         <= xfer_id;
      op_q         <= shift_op_t'(xfer_id ? bus.req_op1 : bus.req_op0);
      in_q         <= xfer_id ? bus.req_in1 : bus.req_in0;
      shamt_q      <= xfer_id ? bus.req_shamt1 : bus.req_shamt0;
    end
  end

  // Shared shift datapath on the latched operands.
  assign sll_res = in_q << shamt_q;
  assign srl_res = in_q >> shamt_q;
  assign sra_res = $signed(in_q) >>> shamt_q;

  always_comb begin
    result     = '0;
    result_err = 1'b0;
    unique case (op_q)
      SHIFT_SLL:     result = sll_res;
      SHIFT_SRL:     result = srl_res;
      SHIFT_SRA:     result = sra_res;
      SHIFT_ILLEGAL: result_err = 1'b1;
      default:       result_err = 1'b1;
    endcase
  end

  // Response registers load only on the CALC->RESP edge, so they hold through
  // any backpressure and a reset clears whatever was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (state_q == S_CALC) begin
      rsp_data_q <= result;
      rsp_id_q   <= id_q;
      rsp_err_q  <= result_err;
    end
  end

  // rsp_valid is a pure state decode: no combinational path from rsp_ready.
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed, table-driven bench for shift_scheduler. Inputs change on the
// falling edge; outputs are sampled 1 ns after a falling edge.
module tb_shift_scheduler;
  import shift_pkg::*;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  shift_scheduler_if #(.N(32)) bus ();

  shift_scheduler #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    shift_op_t   op;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input shift_op_t op, input logic [31:0] din,
                         input logic [4:0] shamt);
    if (id == 0) begin
      bus.req_op0    = op;
      bus.req_in0    = din;
      bus.req_shamt0 = shamt;
    end else begin
      bus.req_op1    = op;
      bus.req_in1    = din;
      bus.req_shamt1 = shamt;
    end
  endtask

  initial begin
    // id = index % 2, so the table ends on requester 1.
    vecs[0] = '{SHIFT_SLL,     32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    vecs[1] = '{SHIFT_SRL,     32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0};
    vecs[2] = '{SHIFT_SRA,     32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{SHIFT_SRA,     32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0};
    vecs[4] = '{SHIFT_SLL,     32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{SHIFT_ILLEGAL, 32'hDEAD_BEEF, 5'd5,  32'h0000_0000, 1'b1};
    vecs[6] = '{SHIFT_SRL,     32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
    vecs[7] = '{SHIFT_SRA,     32'h8000_0010, 5'd4,  32'hF800_0001, 1'b0};
    vecs[8] = '{SHIFT_SLL,     32'h1234_5678, 5'd8,  32'h3456_7800, 1'b0};
    vecs[9] = '{SHIFT_SRA,     32'h0F0F_0F0F, 5'd0,  32'h0F0F_0F0F, 1'b0};

    rst           = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    set_req(0, SHIFT_SLL, 32'h0, 5'd0);
    set_req(1, SHIFT_SLL, 32'h0, 5'd0);

    // Reset state
    @(negedge clk);
    #1;
    check("reset req_ready", {30'b0, bus.req_ready}, 32'h0);
    check("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("reset rsp_data",  bus.rsp_data, 32'h0);
    check("reset rsp_id",    {31'b0, bus.rsp_id}, 32'h0);
    check("reset rsp_err",   {31'b0, bus.rsp_err}, 32'h0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Table: one isolated transaction per vector, consumer always ready
    for (int i = 0; i < 10; i++) begin
      int id;
      id = i % 2;
      @(negedge clk);
      set_req(id, vecs[i].op, vecs[i].din, vecs[i].shamt);
      bus.req_valid = (id == 0) ? 2'b01 : 2'b10;
      #1;
      check($sformatf("v%0d req_ready", i), {30'b0, bus.req_ready}, {30'b0, bus.req_valid});
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      @(negedge clk);
      #1;
      check($sformatf("v%0d calc rsp_valid", i), {31'b0, bus.rsp_valid}, 32'h0);
      @(negedge clk);
      #1;
      check($sformatf("v%0d rsp_valid", i), {31'b0, bus.rsp_valid}, 32'h1);
      check($sformatf("v%0d rsp_data", i),  bus.rsp_data, vecs[i].exp_data);
      check($sformatf("v%0d rsp_id", i),    {31'b0, bus.rsp_id}, id);
      check($sformatf("v%0d rsp_err", i),   {31'b0, bus.rsp_err}, {31'b0, vecs[i].exp_err});
    end

    // Both requesters valid every cycle: grants alternate, one result / 2 cycles
    @(negedge clk);
    set_req(0, SHIFT_SRL, 32'hF000_0000, 5'd4);
    set_req(1, SHIFT_SRA, 32'h8000_0000, 5'd31);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      #1;
      if (p > 0) begin
        check($sformatf("rr%0d rsp_valid", p), {31'b0, bus.rsp_valid}, 32'h1);
        check($sformatf("rr%0d rsp_data", p), bus.rsp_data,
              ((p - 1) % 2 == 0) ? 32'h0F00_0000 : 32'hFFFF_FFFF);
        check($sformatf("rr%0d rsp_id", p), {31'b0, bus.rsp_id}, (p - 1) % 2);
      end
      check($sformatf("rr%0d grant", p), {30'b0, bus.req_ready},
            (p % 2 == 0) ? 32'h1 : 32'h2);
      @(negedge clk);
      #1;
      check($sformatf("rr%0d calc req_ready", p), {30'b0, bus.req_ready}, 32'h0);
      check($sformatf("rr%0d calc rsp_valid", p), {31'b0, bus.rsp_valid}, 32'h0);
      @(negedge clk);
    end
    #1;
    check("rr last rsp_data", bus.rsp_data, 32'hFFFF_FFFF);
    check("rr last rsp_id",   {31'b0, bus.rsp_id}, 32'h1);
    bus.req_valid = 2'b00;

    // Backpressure: result held 5+ cycles while requester 1 waits
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(0, SHIFT_SLL, 32'h0000_0003, 5'd2);
    bus.req_valid = 2'b01;
    #1;
    check("bp req_ready", {30'b0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    set_req(1, SHIFT_SRA, 32'h8000_0000, 5'd1);
    bus.req_valid = 2'b10;
    @(negedge clk);
    #1;
    check("bp calc req_ready", {30'b0, bus.req_ready}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp%0d rsp_valid", k), {31'b0, bus.rsp_valid}, 32'h1);
      check($sformatf("bp%0d rsp_data", k),  bus.rsp_data, 32'h0000_000C);
      check($sformatf("bp%0d req_ready", k), {30'b0, bus.req_ready}, 32'h0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    check("bp handoff req_ready", {30'b0, bus.req_ready}, 32'h2);
    check("bp handoff rsp_data",  bus.rsp_data, 32'h0000_000C);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    check("bp no duplicate", {31'b0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    #1;
    check("bp next rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
    check("bp next rsp_data",  bus.rsp_data, 32'hC000_0000);
    check("bp next rsp_id",    {31'b0, bus.rsp_id}, 32'h1);

    // Asynchronous reset while requester 0's operation is in CALC
    @(negedge clk);
    set_req(0, SHIFT_SLL, 32'hDEAD_BEEF, 5'd4);
    bus.req_valid = 2'b01;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    check("rst rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("rst rsp_data",  bus.rsp_data, 32'h0);
    check("rst rsp_id",    {31'b0, bus.rsp_id}, 32'h0);
    check("rst rsp_err",   {31'b0, bus.rsp_err}, 32'h0);
    bus.req_valid = 2'b11;
    #1;
    check("rst req_ready", {30'b0, bus.req_ready}, 32'h0);
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rst%0d rsp_valid", k), {31'b0, bus.rsp_valid}, 32'h0);
    end
    @(negedge clk);
    set_req(0, SHIFT_SRL, 32'h0000_0100, 5'd8);
    set_req(1, SHIFT_SLL, 32'h0000_0001, 5'd1);
    bus.req_valid = 2'b11;
    #1;
    check("post-rst tie grant", {30'b0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("post-rst rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
    check("post-rst rsp_data",  bus.rsp_data, 32'h0000_0001);
    check("post-rst rsp_id",    {31'b0, bus.rsp_id}, 32'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
